// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO.
// Pointers carry one extra wrap bit above the address.
package fifo_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;

    // Address bits plus one wrap bit, so full and empty are distinguishable.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_if.sv
// Signal bundle for hooking a sync_fifo into a testbench.
// The clock comes in as a port so several bundles can share it.
interface fifo_if #(
    parameter int WIDTH = 8
) (
    input logic clk
);
    logic             rst;
    logic             wr;
    logic             rd;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             full;
    logic             empty;

    modport dut (input clk, rst, wr, rd, din, output dout, full, empty);
    modport tb  (input clk, dout, full, empty, output rst, wr, rd, din);
endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port register array: synchronous write and combinational read.
// The read data is registered by the parent, not here.
module fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: no reset on the array; the pointers alone decide which entries
    // are valid, and a reset here would prevent mapping to plain storage.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: wrap-bit pointers, accept logic, flags and dout register.
// A write into a full FIFO is taken only when a read frees a slot that same edge.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic             rd,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             wr_ok;
    logic             rd_ok;
    logic [WIDTH-1:0] rdata;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);

    // A read while full frees the slot the write lands in on the same edge.
    assign wr_ok = wr && (!full || rd);
    assign rd_ok = rd && !empty;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
            dout <= '0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + PW'(1);
            end
            if (rd_ok) begin
                rptr <= rptr + PW'(1);
                dout <= rdata;
            end
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wptr[AW-1:0]),
        .wdata (din),
        .raddr (rptr[AW-1:0]),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_sync_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    fifo_if #(.WIDTH(WIDTH)) bus (.clk(clk));

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst   (bus.rst),
        .wr    (bus.wr),
        .rd    (bus.rd),
        .din   (bus.din),
        .dout  (bus.dout),
        .full  (bus.full),
        .empty (bus.empty)
    );

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] q [$];
    logic [WIDTH-1:0] m_dout = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: occupancy rules applied to a queue at each rising edge.
    always @(posedge clk) begin
        if (bus.rst) begin
            automatic bit do_rd = bus.rd && (q.size() > 0);
            automatic bit do_wr = bus.wr && ((q.size() < DEPTH) || bus.rd);
            if (do_rd) m_dout = q.pop_front();
            if (do_wr) q.push_back(bus.din);
        end
    end

    // Every-cycle comparison, sampled mid-cycle.
    always @(negedge clk) begin
        check("model_empty", 32'(bus.empty), 32'(q.size() == 0));
        check("model_full",  32'(bus.full),  32'(q.size() == DEPTH));
        check("model_dout",  32'(bus.dout),  32'(m_dout));
    end

    task automatic cycle(input logic w, input logic r, input logic [WIDTH-1:0] d);
        @(negedge clk);
        bus.wr  = w;
        bus.rd  = r;
        bus.din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int hold_ns);
        @(negedge clk);
        #3;
        bus.rst = 1'b0;
        bus.wr  = 1'b0;
        bus.rd  = 1'b0;
        q.delete();
        m_dout = '0;
        #1;
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_full",  32'(bus.full),  32'd0);
        check("rst_dout",  32'(bus.dout),  32'd0);
        #(hold_ns);
        @(negedge clk);
        bus.rst = 1'b1;
    endtask

    initial begin
        bus.rst = 1'b0;
        bus.wr  = 1'b0;
        bus.rd  = 1'b0;
        bus.din = '0;

        // Reset held for 20 ns.
        #20;
        check("por_empty", 32'(bus.empty), 32'd1);
        check("por_full",  32'(bus.full),  32'd0);
        check("por_dout",  32'(bus.dout),  32'd0);
        @(negedge clk);
        bus.rst = 1'b1;

        cycle(1'b0, 1'b1, 8'h00);
        check("rd_after_rst_dout",  32'(bus.dout),  32'd0);
        check("rd_after_rst_empty", 32'(bus.empty), 32'd1);

        // Fill with 0x01..0x10.
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1'b1, 1'b0, 8'(i));
            if (i == 1)         check("first_wr_empty", 32'(bus.empty), 32'd0);
            if (i == DEPTH - 1) check("almost_full",    32'(bus.full),  32'd0);
        end
        check("fill_full", 32'(bus.full), 32'd1);

        // Overflow attempt is dropped.
        cycle(1'b1, 1'b0, 8'hAA);
        check("ovf_full", 32'(bus.full), 32'd1);

        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            check("drain_dout", 32'(bus.dout), 32'(i));
            if (i == 1) check("drain_not_full", 32'(bus.full), 32'd0);
        end
        check("drain_empty", 32'(bus.empty), 32'd1);

        // Underflow: dout holds, pointers stay put.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            check("udf_dout",  32'(bus.dout),  32'h10);
            check("udf_empty", 32'(bus.empty), 32'd1);
        end

        // Read+write while empty: only the write lands.
        cycle(1'b1, 1'b1, 8'h3C);
        check("rw_empty_dout",  32'(bus.dout),  32'h10);
        check("rw_empty_empty", 32'(bus.empty), 32'd0);
        cycle(1'b0, 1'b1, 8'h00);
        check("rw_empty_read", 32'(bus.dout), 32'h3C);

        // Occupancy 5, then 10 cycles of simultaneous read/write.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'(8'h51 + i));
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1, 1'b1, 8'(8'h20 + k));
            check("occ5_dout", 32'(bus.dout), (k < 5) ? 32'(8'h51 + k) : 32'(8'h20 + k - 5));
            check("occ5_size", 32'(q.size()), 32'd5);
        end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            check("occ5_tail", 32'(bus.dout), 32'(8'h25 + i));
        end

        // Full with simultaneous read/write.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 8'(8'h60 + i));
        cycle(1'b1, 1'b1, 8'hEE);
        check("full_rw_dout", 32'(bus.dout), 32'h60);
        check("full_rw_full", 32'(bus.full), 32'd1);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 8'h00);
        check("full_rw_last", 32'(bus.dout), 32'hEE);

        // Mid-operation reset discards contents.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'(8'h90 + i));
        apply_reset(12);
        cycle(1'b0, 1'b0, 8'h00);
        check("post_rst_empty", 32'(bus.empty), 32'd1);

        // Randomized traffic, long enough to wrap the pointers several times.
        for (int n = 0; n < 400; n++) begin
            automatic logic w = ($urandom_range(0, 99) < ((n / 50) % 2 == 0 ? 70 : 35));
            automatic logic r = ($urandom_range(0, 99) < ((n / 50) % 2 == 0 ? 35 : 70));
            cycle(w, r, 8'($urandom));
        end

        cycle(1'b0, 1'b0, 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
